// File: rtl/data_memory_ip_if.sv
// Load/store bus between the CPU datapath and the data RAM.
// The CPU side drives address, data and write enable; the RAM returns registered read data.
interface data_memory_ip_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output address,
    output data,
    output wren,
    input  q
  );

  modport slave (
    input  address,
    input  data,
    input  wren,
    output q
  );

endinterface

// File: rtl/data_memory_ip.sv
// Single-port word-addressed data RAM with a read-first registered output.
// Only the output register has the asynchronous active-low reset; the array has none.
module data_memory_ip #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_memory_ip_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] INIT_WORD =
    (INIT_ZERO != 0) ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'bx}};

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};

  // rst gates the write enable so stores are dropped while the core is held in reset.
  always_ff @(posedge clk) begin
    if (rst && bus.wren) begin
      mem[bus.address] <= bus.data;
    end
  end

  // Reads the pre-write contents on a same-address store (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.q <= '0;
    end else begin
      bus.q <= mem[bus.address];
    end
  end

  a_ctrl_known : assert property (
    @(posedge clk) disable iff (!rst)
      !$isunknown(bus.wren) && !$isunknown(bus.address)
  );

endmodule

// File: tb/tb_data_memory_ip.sv
// Scoreboard bench for data_memory_ip: expected read data is queued as each access is driven
// and popped when the registered output is sampled after the edge.
module tb_data_memory_ip;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4096;

  logic clk = 1'b0;
  logic rst;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  data_memory_ip_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_ip #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH),
    .INIT_ZERO (1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: q=%h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; drives one access, checks q after the rising edge and again
  // just before the next falling edge to confirm it holds.
  task automatic step(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic w);
    logic [DW-1:0] e;
    bus.address = a;
    bus.data    = d;
    bus.wren    = w;
    exp_q.push_back(model[a]);
    if (w) model[a] = d;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, bus.q, e);
    @(negedge clk);
    check_eq({tag, "_hold"}, bus.q, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ra;
    int unsigned   r;

    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    rst         = 1'b0;
    bus.wren    = 1'b1;
    bus.address = AW'(5);
    bus.data    = 32'hDEAD_BEEF;

    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("rst_q", bus.q, '0);
    end
    @(negedge clk);
    rst = 1'b1;
    step("rst_write_blocked", AW'(5), '0, 1'b0);

    step("wr_addr0",    AW'(0),    32'h1234_5678, 1'b1);
    step("wr_addr4095", AW'(4095), 32'hFFFF_FFFF, 1'b1);
    step("rd_addr0",    AW'(0),    '0, 1'b0);
    step("rd_addr4095", AW'(4095), '0, 1'b0);
    step("rd_addr0_b",  AW'(0),    '0, 1'b0);

    // Mid-cycle async reset with q holding 0x12345678.
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst_immediate", bus.q, '0);
    @(posedge clk);
    #1;
    check_eq("async_rst_held", bus.q, '0);
    @(negedge clk);
    rst = 1'b1;
    step("retained_addr0", AW'(0), '0, 1'b0);

    step("rdw_setup", AW'(10), DW'(7), 1'b1);
    step("rdw_old",   AW'(10), DW'(9), 1'b1);
    step("rdw_new",   AW'(10), '0,     1'b0);

    for (int n = 0; n < 3; n++) step("seq_wr", AW'(n), DW'(100 + n), 1'b1);
    for (int n = 0; n < 3; n++) step("seq_rd", AW'(n), '0, 1'b0);

    for (int v = 1; v <= 3; v++) step("b2b_wr", AW'(30), DW'(v), 1'b1);
    step("b2b_rd", AW'(30), '0, 1'b0);

    repeat (24) begin
      r  = $urandom_range(0, 15);
      ra = (r < 8) ? AW'(r) : AW'(4080 + r);
      step("rand", ra, DW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ip.md
Name: data_memory_ip

Overview:
- Single-port synchronous data RAM for the single-cycle CPU's load/store path: 4096 words × 32 bits, word-addressed.
- The CPU drives its clock input with the inverted core clock, so a memory edge falls mid-cycle. A store addressed in a cycle commits, and a load's data appears on q, before the next core rising edge.
- Models the vendor single-port RAM (no read enable), with an active-low asynchronous reset added on the output register.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 12, address width in bits.
- DEPTH, 4096, number of words (must equal 2**ADDR_WIDTH).
- INIT_ZERO, 1, when 1 every word is zero at power-up/simulation start.

Ports:
- clk  input  1  memory clock; all sampling on rising edge (CPU connects ~core_clk).
- rst  input  1  asynchronous reset, active-low.
- address  input  ADDR_WIDTH  word address; CPU passes ALU result bits [11:0].
- data  input  DATA_WIDTH  write data (CPU readData2).
- wren  input  1  write enable, active-high.
- q  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset value of the only output: q = 0 whenever rst is low (asynchronous assert).
  - Reset clears only q; array contents are not cleared.
  - Writes are blocked while rst is low.
- Deassertion of rst is synchronous-safe: the first rising clk edge with rst high performs normal operation.
- Power-up contents: all words 0 when INIT_ZERO=1; otherwise undefined (X in simulation).
- Read: every rising clk edge with rst high does q <= mem[address]. There is no read enable; reads are unconditional.
- Read latency: 1 edge. q reflects the address sampled at the most recent rising edge and holds until the next edge.
- Write: on a rising clk edge with rst high and wren=1, mem[address] <= data. Exactly one word changes.
- Read-during-write, same address, same edge: q returns the OLD contents. The new value is visible on the following edge.
- Addressing:
  - Full ADDR_WIDTH range is valid, 0 to DEPTH-1; no wrap logic is needed beyond natural truncation.
  - The caller supplies only the low ADDR_WIDTH bits, so higher CPU address bits alias by construction.
- X handling: if wren is X or address is X while rst is high, no defined word may be corrupted in synthesis. Simulation may flag it with an assertion.
- No combinational path from any input to q.
- Implementation must infer block RAM. The reset applies only to the output register, not to the array.

Test Plan:
- Reset: hold rst=0 for 3 clk edges with wren=1, address=5, data=32'hDEAD_BEEF.
  -> q=0 throughout.
  -> After rst=1, a read of address 5 returns 0, proving the write was blocked.
- Write/read back: write 32'h1234_5678 to address 0 and 32'hFFFF_FFFF to address 4095, then read address 0 then 4095.
  -> q=32'h1234_5678 one edge after sampling address 0.
  -> q=32'hFFFF_FFFF one edge after sampling address 4095.
- Read-during-write: mem[10]=7; on one edge drive wren=1, address=10, data=9.
  -> q=7 after that edge.
  -> The next edge with wren=0, address=10 gives q=9.
- Unconditional read and hold: wren=0, change address 0→1→2 with mem[n]=n+100.
  -> q sequences 100, 101, 102, each one edge late; q stable between edges.
- Async reset mid-operation: with q=32'h1234_5678, pull rst low between clk edges.
  -> q=0 immediately, without waiting for an edge.
  -> After release, reading address 0 returns 32'h1234_5678, proving contents were retained.
- Back-to-back writes to the same address (values 1, 2, 3 on consecutive edges), then read.
  -> Final read q=3; q during the writes shows the prior value each time (0, 1, 2).
